// File: rtl/fixed_power.sv
// Iterative Q10.10 exponentiation x^n (n = 0..7): one truncating multiply per cycle,
// saturating to all-ones on overflow. Result is presented for one registered cycle.
module fixed_power #(
    parameter int DATA_W = 20,
    parameter int FRAC_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,      // active-high despite the name
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [2:0]        in_data_2,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [2:0]          n_q, n_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_sat_q, out_sat_d;

    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] shifted;
    logic                ovf;
    logic [2:0]          cnt_inc;
    logic                accept;

    assign prod    = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, x_q};
    assign shifted = prod >> FRAC_W;
    assign ovf     = |shifted[2*DATA_W-1:DATA_W];
    assign cnt_inc = cnt_q + 3'd1;

    // The result cycle still counts as busy, so a new request lands one edge after it.
    assign busy   = (state_q != IDLE) | out_valid_q;
    assign accept = in_valid & ~busy;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (in_data_2 == 3'd0) ? OUT : MUL;
            MUL:  if (ovf || cnt_inc == n_q) state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d         = x_q;
        n_d         = n_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_sat_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d   = in_data_1;
                    n_d   = in_data_2;
                    acc_d = ONE;
                    cnt_d = 3'd0;
                    sat_d = 1'b0;
                end
            end
            MUL: begin
                // Overflow ends the run early; remaining multiplies would only stay saturated.
                if (ovf) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = shifted[DATA_W-1:0];
                    cnt_d = cnt_inc;
                end
            end
            OUT: begin
                out_valid_d = 1'b1;
                out_data_d  = acc_q;
                out_sat_d   = sat_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fixed_power.sv
// Randomized and directed checks of fixed_power against an arithmetic reference model.
module tb_fixed_power;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] in_data_1;
    logic [2:0]  in_data_2;
    logic        busy;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    fixed_power #(.DATA_W(20), .FRAC_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data_1(in_data_1),
        .in_data_2(in_data_2), .busy(busy), .out_valid(out_valid),
        .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // Real-valued repeated multiplication with floor truncation; clamps at the first overflow.
    function automatic void ref_pow(input logic [19:0] x, input logic [2:0] n,
                                    output logic [19:0] r, output logic s, output int lat);
        longint unsigned acc;
        acc = 1024;
        s   = 1'b0;
        lat = int'(n) + 1;
        for (int i = 0; i < int'(n); i++) begin
            acc = (acc * longint'(x)) / 1024;
            if (acc > 64'hFFFFF) begin
                acc = 64'hFFFFF;
                s   = 1'b1;
                lat = i + 2;
                break;
            end
        end
        r = acc[19:0];
    endfunction

    function automatic logic [19:0] rand_x();
        case ($urandom_range(0, 2))
            0:       return 20'($urandom_range(0, 'h7FF));
            1:       return 20'($urandom_range(0, 'h1FFF));
            default: return 20'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_data_1 = '0; in_data_2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, out_valid, out_data, out_sat} !== 23'd0)
            begin errors++; $display("FAIL reset_state: got b=%b v=%b d=%h s=%b want all 0", busy, out_valid, out_data, out_sat); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: got b=%b v=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_power();
        logic [19:0] xs[$];
        logic [2:0]  ns[$];
        logic [19:0] r;
        logic        s;
        int          lat;
        xs = '{20'h00600, 20'h00800, 20'h00000, 20'h00401, 20'h0FC00, 20'h00C00, 20'h00000, 20'hFFFFF, 20'h12345};
        ns = '{3'd2,      3'd7,      3'd0,      3'd2,      3'd3,      3'd4,      3'd5,      3'd1,      3'd0};
        for (int i = 0; i < 40; i++) begin
            xs.push_back(rand_x());
            ns.push_back(3'($urandom_range(0, 7)));
        end
        foreach (xs[k]) begin
            ref_pow(xs[k], ns[k], r, s, lat);
            @(negedge clk);
            in_valid = 1'b1; in_data_1 = xs[k]; in_data_2 = ns[k];
            @(negedge clk);
            in_valid = 1'b0; in_data_1 = 20'($urandom); in_data_2 = 3'($urandom);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL power_busy_rise[%0d]: got %b want 1", k, busy); end
            for (int c = 1; c <= lat + 1; c++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'(c == lat))
                    begin errors++; $display("FAIL power_valid[%0d] cyc %0d: got %b want %b", k, c, out_valid, c == lat); end
                checks++;
                if (c == lat) begin
                    if (out_data !== r || out_sat !== s)
                        begin errors++; $display("FAIL power_result[%0d] x=%h n=%0d: got %h/%b want %h/%b", k, xs[k], ns[k], out_data, out_sat, r, s); end
                end else if (out_data !== 20'd0 || out_sat !== 1'b0)
                    begin errors++; $display("FAIL power_idle_zero[%0d] cyc %0d: got %h/%b want 0/0", k, c, out_data, out_sat); end
                checks++;
                if (busy !== 1'(c <= lat))
                    begin errors++; $display("FAIL power_busy[%0d] cyc %0d: got %b want %b", k, c, busy, c <= lat); end
            end
        end
    endtask

    task automatic test_busy();
        int pulses = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data_1 = 20'h00C00; in_data_2 = 3'd4;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
            checks++;
            if (c == 5 && out_data !== 20'h14400)
                begin errors++; $display("FAIL busy_result: got %h want 14400", out_data); end
            else if (c != 5 && out_valid !== 1'b0)
                begin errors++; $display("FAIL busy_valid cyc %0d: got %b want 0", c, out_valid); end
            // Intruding requests during MUL, OUT and the result cycle.
            in_valid = (c == 2 || c == 4 || c == 5);
            in_data_1 = 20'h00800; in_data_2 = 3'd1;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL busy_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] xs[$];
        logic [2:0]  ns[$];
        logic [19:0] r;
        logic        s;
        int          lat;
        for (int i = 0; i < 20; i++) begin
            xs.push_back(rand_x());
            ns.push_back(3'($urandom_range(0, 7)));
        end
        @(negedge clk);
        in_valid = 1'b1; in_data_1 = xs[0]; in_data_2 = ns[0];
        foreach (xs[k]) begin
            ref_pow(xs[k], ns[k], r, s, lat);
            @(negedge clk);
            in_valid = 1'b0; in_data_1 = 20'($urandom);
            for (int c = 1; c <= lat + 1; c++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'(c == lat))
                    begin errors++; $display("FAIL b2b_valid[%0d] cyc %0d: got %b want %b", k, c, out_valid, c == lat); end
                if (c == lat) begin
                    checks++;
                    if (out_data !== r || out_sat !== s)
                        begin errors++; $display("FAIL b2b_result[%0d] x=%h n=%0d: got %h/%b want %h/%b", k, xs[k], ns[k], out_data, out_sat, r, s); end
                    // Next request is presented one cycle early; it must wait until busy drops.
                    if (k + 1 < xs.size()) begin
                        in_valid = 1'b1; in_data_1 = xs[k+1]; in_data_2 = ns[k+1];
                    end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_data_1 = 20'h00800; in_data_2 = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({busy, out_valid, out_data, out_sat} !== 23'd0)
            begin errors++; $display("FAIL reset_mid_async: got b=%b v=%b d=%h s=%b want all 0", busy, out_valid, out_data, out_sat); end
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1; in_data_1 = 20'h00400; in_data_2 = 3'd5;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'(c == 6))
                begin errors++; $display("FAIL reset_mid_valid cyc %0d: got %b want %b", c, out_valid, c == 6); end
            if (c == 6) begin
                checks++;
                if (out_data !== 20'h00400 || out_sat !== 1'b0)
                    begin errors++; $display("FAIL reset_mid_result: got %h/%b want 00400/0", out_data, out_sat); end
            end
        end
        // Reset landing on the result cycle must clear the registered outputs at once.
        in_valid = 1'b1; in_data_1 = 20'h0FC00; in_data_2 = 3'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sat !== 1'b1)
            begin errors++; $display("FAIL reset_out_pre: got v=%b s=%b want 1 1", out_valid, out_sat); end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if ({busy, out_valid, out_data, out_sat} !== 23'd0)
            begin errors++; $display("FAIL reset_out_async: got b=%b v=%b d=%h s=%b want all 0", busy, out_valid, out_data, out_sat); end
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
